// File: rtl/sprite_draw_if.sv
// Sprite-to-ROM read port: registered address out, palette index back one cycle later.
interface sprite_draw_if #(
  parameter int AW       = 12,
  parameter int IDX_BITS = 4
);
  logic [AW-1:0]       rom_addr;
  logic [IDX_BITS-1:0] rom_q;

  modport master (output rom_addr, input  rom_q);
  modport slave  (input  rom_addr, output rom_q);
endinterface

// File: rtl/sprite_draw.sv
// Single-sprite renderer: maps the scan position onto a texel of an animated,
// optionally mirrored and magnified sprite, fetches its palette index from a
// synchronous ROM and emits the pixel two clocks after the scan position.
module sprite_draw #(
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int SCALE_LOG2 = 0,
  parameter int N_FRAMES   = 4,
  parameter int IDX_BITS   = 4,
  parameter int TRANSP_IDX = 0,
  parameter int ANIM_DIV   = 8,
  localparam int AW = $clog2(N_FRAMES * SPR_W * SPR_H),
  localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
  input  logic                vga_clk,
  input  logic                Reset,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic                blank,
  input  logic                frame_start,
  input  logic [9:0]          pos_x,
  input  logic [9:0]          pos_y,
  input  logic                flip_h,
  input  logic                flip_v,
  input  logic                enable,
  input  logic                anim_en,
  input  logic [FW-1:0]       frame_sel,
  sprite_draw_if.master       rom,
  output logic [IDX_BITS-1:0] pix_idx,
  output logic                pix_opaque,
  output logic                blank_o
);

  localparam int UW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int VW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [10:0] SPAN_X = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0] SPAN_Y = 11'(SPR_H << SCALE_LOG2);
  localparam logic [FW:0] NF     = (FW + 1)'(N_FRAMES);

  logic [9:0]    r_sx, r_sy;
  logic          r_flip_h, r_flip_v, r_en;
  logic [FW-1:0] r_frame;
  logic [DW-1:0] r_div;
  logic          r_inside_d1, r_inside_d2, r_blank_d1, r_blank_d2;

  logic [10:0]   w_dx, w_dy;
  logic          w_inside;
  logic [UW-1:0] w_u_raw, w_u;
  logic [VW-1:0] w_v_raw, w_v;
  logic [AW-1:0] w_addr;

  // Stage 0: sprite-relative offset, hit test and texel address.
  // Offsets are widened to 11 bits and hit-tested with the >= guards, so a
  // sprite hanging past the right/bottom edge clips instead of wrapping.
  always_comb begin
    w_dx     = {1'b0, DrawX} - {1'b0, r_sx};
    w_dy     = {1'b0, DrawY} - {1'b0, r_sy};
    w_inside = (DrawX >= r_sx) && (DrawY >= r_sy) && (w_dx < SPAN_X) && (w_dy < SPAN_Y);
    w_u_raw  = UW'(w_dx >> SCALE_LOG2);
    w_v_raw  = VW'(w_dy >> SCALE_LOG2);
    w_u      = r_flip_h ? (UW'(SPR_W - 1) - w_u_raw) : w_u_raw;
    w_v      = r_flip_v ? (VW'(SPR_H - 1) - w_v_raw) : w_v_raw;
    w_addr   = AW'(r_frame) * AW'(SPR_W * SPR_H) + AW'(w_v) * AW'(SPR_W) + AW'(w_u);
  end

  // Per-video-frame state: shadow registers and animation frame, updated only in vblank.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_sx     <= '0;
      r_sy     <= '0;
      r_flip_h <= 1'b0;
      r_flip_v <= 1'b0;
      r_en     <= 1'b0;
      r_frame  <= '0;
      r_div    <= '0;
    end else if (frame_start) begin
      r_sx     <= pos_x;
      r_sy     <= pos_y;
      r_flip_h <= flip_h;
      r_flip_v <= flip_v;
      r_en     <= enable;
      if (anim_en) begin
        if (r_div == DW'(ANIM_DIV - 1)) begin
          r_div   <= '0;
          r_frame <= (r_frame == FW'(N_FRAMES - 1)) ? '0 : r_frame + FW'(1);
        end else begin
          r_div <= r_div + DW'(1);
        end
      end else begin
        r_div <= '0;
        if ({1'b0, frame_sel} < NF) r_frame <= frame_sel;
      end
    end
  end

  // ROM address register plus two-deep delay of hit/blank to line up with rom_q.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      rom.rom_addr <= '0;
      r_inside_d1  <= 1'b0;
      r_inside_d2  <= 1'b0;
      r_blank_d1   <= 1'b0;
      r_blank_d2   <= 1'b0;
    end else begin
      rom.rom_addr <= w_inside ? w_addr : '0;
      r_inside_d1  <= w_inside;
      r_inside_d2  <= r_inside_d1;
      r_blank_d1   <= blank;
      r_blank_d2   <= r_blank_d1;
    end
  end

  // Output stage: register the palette index and the opacity decision.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      pix_idx    <= '0;
      pix_opaque <= 1'b0;
      blank_o    <= 1'b0;
    end else begin
      pix_idx    <= rom.rom_q;
      pix_opaque <= r_inside_d2 & r_en & r_blank_d2 & (rom.rom_q != IDX_BITS'(TRANSP_IDX));
      blank_o    <= r_blank_d2;
    end
  end

endmodule

// File: tb/tb_sprite_draw.sv
// Bench for sprite_draw: two instances (1x and 2x magnification) share all
// scan/control inputs, each reads its own model ROM built from one table.
module tb_sprite_draw;
  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] DrawX, DrawY, pos_x, pos_y;
  logic       blank, frame_start, flip_h, flip_v, enable, anim_en;
  logic [1:0] frame_sel;
  logic [3:0] pix_idx0, pix_idx1;
  logic       pix_opaque0, pix_opaque1, blank_o0, blank_o1;
  logic [3:0] rom_mem [0:4095];
  logic [11:0] o_a0, o_a1;

  int n_pass = 0;
  int n_total = 0;

  // reference state: what the sprite should currently look like
  int m_sx, m_sy, m_frame, m_tick;
  bit m_fh, m_fv, m_en;

  sprite_draw_if #(.AW(12), .IDX_BITS(4)) bus0 ();
  sprite_draw_if #(.AW(12), .IDX_BITS(4)) bus1 ();

  sprite_draw #(.ANIM_DIV(2)) dut0 (
    .vga_clk(clk), .Reset(rst), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h),
    .flip_v(flip_v), .enable(enable), .anim_en(anim_en), .frame_sel(frame_sel),
    .rom(bus0.master), .pix_idx(pix_idx0), .pix_opaque(pix_opaque0), .blank_o(blank_o0));

  sprite_draw #(.SCALE_LOG2(1), .ANIM_DIV(2)) dut1 (
    .vga_clk(clk), .Reset(rst), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h),
    .flip_v(flip_v), .enable(enable), .anim_en(anim_en), .frame_sel(frame_sel),
    .rom(bus1.master), .pix_idx(pix_idx1), .pix_opaque(pix_opaque1), .blank_o(blank_o1));

  always #5 clk = ~clk;

  // synchronous ROMs, one-cycle read latency
  always @(posedge clk) begin
    bus0.rom_q <= rom_mem[bus0.rom_addr];
    bus1.rom_q <= rom_mem[bus1.rom_addr];
  end

  function automatic bit exp_in(input int s, input int x, input int y);
    int w = 32 << s;
    return (x >= m_sx) && (y >= m_sy) && (x - m_sx < w) && (y - m_sy < w);
  endfunction

  function automatic int exp_addr(input int s, input int x, input int y);
    int u, v;
    if (!exp_in(s, x, y)) return 0;
    u = (x - m_sx) >> s;
    v = (y - m_sy) >> s;
    if (m_fh) u = 31 - u;
    if (m_fv) v = 31 - v;
    return m_frame * 1024 + v * 32 + u;
  endfunction

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_fh = 0; m_fv = 0; m_en = 0; m_frame = 0; m_tick = 0;
  endtask

  // one-cycle frame_start pulse during vertical blank
  task automatic pulse();
    blank = 1'b0;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    m_sx = int'(pos_x); m_sy = int'(pos_y);
    m_fh = flip_h; m_fv = flip_v; m_en = enable;
    if (anim_en) begin
      m_tick++;
      if (m_tick == 2) begin
        m_tick = 0;
        m_frame = (m_frame + 1) % 4;
      end
    end else begin
      m_tick = 0;
      m_frame = int'(frame_sel);
    end
  endtask

  // hold one scan position: rom_addr captured after 1 edge, pixel outputs settled after 3
  task automatic px(input int x, input int y, input bit b);
    DrawX = 10'(x); DrawY = 10'(y); blank = b;
    @(posedge clk); #1;
    o_a0 = bus0.rom_addr;
    o_a1 = bus1.rom_addr;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic setup(input int x, input int y, input bit fh, input bit fv,
                       input bit en, input int fs);
    pos_x = 10'(x); pos_y = 10'(y); flip_h = fh; flip_v = fv;
    enable = en; anim_en = 1'b0; frame_sel = 2'(fs);
    pulse();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    DrawX = 10'd10; DrawY = 10'd10; blank = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_total++; if (bus0.rom_addr !== 12'd0) $display("FAIL reset_rom_addr got %0d exp 0", bus0.rom_addr); else n_pass++;
    n_total++; if (pix_idx0 !== 4'd0) $display("FAIL reset_pix_idx got %0d exp 0", pix_idx0); else n_pass++;
    n_total++; if (pix_opaque0 !== 1'b0) $display("FAIL reset_pix_opaque got %0b exp 0", pix_opaque0); else n_pass++;
    n_total++; if (blank_o0 !== 1'b0) $display("FAIL reset_blank_o got %0b exp 0", blank_o0); else n_pass++;
    n_total++; if (bus1.rom_addr !== 12'd0) $display("FAIL reset_rom_addr_x2 got %0d exp 0", bus1.rom_addr); else n_pass++;
    rst = 1'b0;
    model_reset();
    // enable=1 presented but never latched: still transparent
    enable = 1'b1;
    rom_mem[330] = 4'd6;
    px(10, 10, 1'b1);
    n_total++; if (o_a0 !== 12'd330) $display("FAIL reset_unlatched_addr got %0d exp 330", o_a0); else n_pass++;
    n_total++; if (pix_opaque0 !== 1'b0) $display("FAIL reset_unlatched_opaque got %0b exp 0", pix_opaque0); else n_pass++;
  endtask

  task automatic test_basic();
    rom_mem[0] = 4'd5;
    setup(100, 50, 0, 0, 1, 0);
    px(100, 50, 1'b1);
    n_total++; if (o_a0 !== 12'd0) $display("FAIL basic_origin_addr got %0d exp 0", o_a0); else n_pass++;
    n_total++; if (pix_idx0 !== 4'd5) $display("FAIL basic_origin_idx got %0d exp 5", pix_idx0); else n_pass++;
    n_total++; if (pix_opaque0 !== 1'b1) $display("FAIL basic_origin_opaque got %0b exp 1", pix_opaque0); else n_pass++;
    n_total++; if (blank_o0 !== 1'b1) $display("FAIL basic_origin_blank got %0b exp 1", blank_o0); else n_pass++;
    px(131, 81, 1'b1);
    n_total++; if (o_a0 !== 12'd1023) $display("FAIL basic_corner_addr got %0d exp 1023", o_a0); else n_pass++;
    px(132, 81, 1'b1);
    n_total++; if (o_a0 !== 12'd0) $display("FAIL basic_right_addr got %0d exp 0", o_a0); else n_pass++;
    n_total++; if (pix_opaque0 !== 1'b0) $display("FAIL basic_right_opaque got %0b exp 0", pix_opaque0); else n_pass++;
    n_total++; if (o_a1 !== 12'd496) $display("FAIL basic_right_addr_x2 got %0d exp 496", o_a1); else n_pass++;
  endtask

  task automatic test_flip();
    setup(100, 50, 1, 1, 1, 2);
    px(100, 50, 1'b1);
    n_total++; if (o_a0 !== 12'd3071) $display("FAIL flip_origin_addr got %0d exp 3071", o_a0); else n_pass++;
    n_total++; if (o_a1 !== 12'd3071) $display("FAIL flip_origin_addr_x2 got %0d exp 3071", o_a1); else n_pass++;
    px(131, 81, 1'b1);
    n_total++; if (o_a0 !== 12'd2048) $display("FAIL flip_corner_addr got %0d exp 2048", o_a0); else n_pass++;
  endtask

  task automatic test_scale();
    rom_mem[1023] = 4'd3;
    rom_mem[33] = 4'd0;
    setup(0, 0, 0, 0, 1, 0);
    px(63, 63, 1'b1);
    n_total++; if (o_a1 !== 12'd1023) $display("FAIL scale_corner_addr got %0d exp 1023", o_a1); else n_pass++;
    n_total++; if (pix_opaque1 !== 1'b1) $display("FAIL scale_corner_opaque got %0b exp 1", pix_opaque1); else n_pass++;
    n_total++; if (o_a0 !== 12'd0) $display("FAIL scale_corner_addr_x1 got %0d exp 0", o_a0); else n_pass++;
    px(64, 63, 1'b1);
    n_total++; if (o_a1 !== 12'd0) $display("FAIL scale_outside_addr got %0d exp 0", o_a1); else n_pass++;
    n_total++; if (pix_opaque1 !== 1'b0) $display("FAIL scale_outside_opaque got %0b exp 0", pix_opaque1); else n_pass++;
    px(2, 2, 1'b1);
    n_total++; if (o_a1 !== 12'd33) $display("FAIL scale_transp_addr got %0d exp 33", o_a1); else n_pass++;
    n_total++; if (pix_opaque1 !== 1'b0) $display("FAIL scale_transp_opaque got %0b exp 0", pix_opaque1); else n_pass++;
    n_total++; if (pix_idx1 !== 4'd0) $display("FAIL scale_transp_idx got %0d exp 0", pix_idx1); else n_pass++;
    n_total++; if (o_a0 !== 12'd66) $display("FAIL scale_transp_addr_x1 got %0d exp 66", o_a0); else n_pass++;
  endtask

  task automatic test_clip();
    rom_mem[19] = 4'd9;
    setup(620, 0, 0, 0, 1, 0);
    px(639, 0, 1'b1);
    n_total++; if (o_a0 !== 12'd19) $display("FAIL clip_edge_addr got %0d exp 19", o_a0); else n_pass++;
    n_total++; if (pix_opaque0 !== 1'b1) $display("FAIL clip_edge_opaque got %0b exp 1", pix_opaque0); else n_pass++;
    for (int x = 0; x < 12; x++) begin
      px(x, 0, 1'b1);
      n_total++; if (o_a0 !== 12'd0) $display("FAIL clip_wrap_addr x=%0d got %0d exp 0", x, o_a0); else n_pass++;
      n_total++; if (pix_opaque0 !== 1'b0) $display("FAIL clip_wrap_opaque x=%0d got %0b exp 0", x, pix_opaque0); else n_pass++;
      n_total++; if (o_a1 !== 12'd0) $display("FAIL clip_wrap_addr_x2 x=%0d got %0d exp 0", x, o_a1); else n_pass++;
    end
  endtask

  task automatic test_anim();
    int tbl [8];
    int exp_a;
    tbl = '{0, 1, 1, 2, 2, 3, 3, 0};
    setup(100, 50, 0, 0, 1, 0);
    anim_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pulse();
      if (i == 0) begin
        pos_x = 10'd300;      // moved mid-frame: must not show yet
        px(101, 50, 1'b1);
        exp_a = 1;
      end else begin
        px(300, 50, 1'b1);
        exp_a = tbl[i] * 1024;
      end
      n_total++; if (int'(o_a0) != exp_a) $display("FAIL anim_pulse%0d_addr got %0d exp %0d", i + 1, o_a0, exp_a); else n_pass++;
    end
    anim_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int hx [3], hy [3];
    bit hb [3];
    int x, y, j, a;
    logic [3:0] e_idx;
    bit e_op;
    for (int r = 0; r < 4; r++) begin
      setup(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            (r != 2), int'($urandom_range(0, 3)));
      for (int k = 0; k < 60; k++) begin
        x = m_sx + int'($urandom_range(0, 90)) - 12;
        y = m_sy + int'($urandom_range(0, 90)) - 12;
        if (x < 0) x = 0;
        if (x > 639) x = 639;
        if (y < 0) y = 0;
        if (y > 479) y = 479;
        hx[k % 3] = x; hy[k % 3] = y; hb[k % 3] = ($urandom_range(0, 7) != 0);
        DrawX = 10'(x); DrawY = 10'(y); blank = hb[k % 3];
        @(posedge clk); #1;
        n_total++; if (int'(bus0.rom_addr) != exp_addr(0, x, y)) $display("FAIL b2b_addr (%0d,%0d) got %0d exp %0d", x, y, bus0.rom_addr, exp_addr(0, x, y)); else n_pass++;
        n_total++; if (int'(bus1.rom_addr) != exp_addr(1, x, y)) $display("FAIL b2b_addr_x2 (%0d,%0d) got %0d exp %0d", x, y, bus1.rom_addr, exp_addr(1, x, y)); else n_pass++;
        if (k >= 2) begin
          j = (k - 2) % 3;
          a = exp_addr(0, hx[j], hy[j]);
          e_idx = rom_mem[a];
          e_op = exp_in(0, hx[j], hy[j]) && m_en && hb[j] && (e_idx != 4'd0);
          n_total++; if (pix_idx0 !== e_idx) $display("FAIL b2b_idx got %0d exp %0d", pix_idx0, e_idx); else n_pass++;
          n_total++; if (pix_opaque0 !== e_op) $display("FAIL b2b_opaque got %0b exp %0b", pix_opaque0, e_op); else n_pass++;
          n_total++; if (blank_o0 !== hb[j]) $display("FAIL b2b_blank got %0b exp %0b", blank_o0, hb[j]); else n_pass++;
          a = exp_addr(1, hx[j], hy[j]);
          e_idx = rom_mem[a];
          e_op = exp_in(1, hx[j], hy[j]) && m_en && hb[j] && (e_idx != 4'd0);
          n_total++; if (pix_idx1 !== e_idx) $display("FAIL b2b_idx_x2 got %0d exp %0d", pix_idx1, e_idx); else n_pass++;
          n_total++; if (pix_opaque1 !== e_op) $display("FAIL b2b_opaque_x2 got %0b exp %0b", pix_opaque1, e_op); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset_collision();
    setup(100, 50, 0, 0, 1, 3);
    rom_mem[165] = 4'd7;
    DrawX = 10'd110; DrawY = 10'd60; blank = 1'b1;
    rst = 1'b1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus0.rom_addr !== 12'd0) $display("FAIL coll_rom_addr got %0d exp 0", bus0.rom_addr); else n_pass++;
    n_total++; if (pix_idx0 !== 4'd0) $display("FAIL coll_pix_idx got %0d exp 0", pix_idx0); else n_pass++;
    n_total++; if (pix_opaque0 !== 1'b0) $display("FAIL coll_pix_opaque got %0b exp 0", pix_opaque0); else n_pass++;
    n_total++; if (blank_o0 !== 1'b0) $display("FAIL coll_blank_o got %0b exp 0", blank_o0); else n_pass++;
    rst = 1'b0;
    frame_start = 1'b0;
    model_reset();
    px(5, 5, 1'b1);
    n_total++; if (o_a0 !== 12'd165) $display("FAIL coll_frame_cleared_addr got %0d exp 165", o_a0); else n_pass++;
    n_total++; if (pix_idx0 !== 4'd7) $display("FAIL coll_idx got %0d exp 7", pix_idx0); else n_pass++;
    n_total++; if (pix_opaque0 !== 1'b0) $display("FAIL coll_opaque got %0b exp 0", pix_opaque0); else n_pass++;
    n_total++; if (blank_o0 !== 1'b1) $display("FAIL coll_blank_after got %0b exp 1", blank_o0); else n_pass++;
    px(110, 60, 1'b1);
    n_total++; if (pix_opaque0 !== 1'b0) $display("FAIL coll_old_pos_opaque got %0b exp 0", pix_opaque0); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    rst = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0; frame_start = 1'b0;
    pos_x = '0; pos_y = '0; flip_h = 1'b0; flip_v = 1'b0; enable = 1'b0;
    anim_en = 1'b0; frame_sel = '0;
    model_reset();
    test_reset();
    test_basic();
    test_flip();
    test_scale();
    test_clip();
    test_anim();
    test_back_to_back();
    test_reset_collision();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sprite_draw.md
SPRITE_DRAW -- requirements
Module: sprite_draw

Interface
REQ-001 Parameter SPR_W, default 32: sprite width in texels (power of 2).
REQ-002 Parameter SPR_H, default 32: sprite height in texels (power of 2).
REQ-003 Parameter SCALE_LOG2, default 0: on-screen magnification is 2^SCALE_LOG2 pixels per texel.
REQ-004 Parameter N_FRAMES, default 4: animation frames stored back-to-back in ROM.
REQ-005 Parameter IDX_BITS, default 4: palette index width.
REQ-006 Parameter TRANSP_IDX, default 0: palette index treated as transparent.
REQ-007 Parameter ANIM_DIV, default 8 (>=1): video frames per animation step.
REQ-008 Derived AW = clog2(N_FRAMES*SPR_W*SPR_H); FW = max(1, clog2(N_FRAMES)).
REQ-009 One clock; reset is synchronous and active-high.
REQ-010 vga_clk  in  1  pixel clock; all state updates on rising edge.
REQ-011 Reset  in  1  synchronous active-high reset.
REQ-012 DrawX, DrawY  in  10 each  current scan pixel.
REQ-013 blank  in  1  1 = active video.
REQ-014 frame_start  in  1  one-cycle pulse at start of vertical blank.
REQ-015 pos_x, pos_y  in  10 each  sprite top-left corner, screen pixels.
REQ-016 flip_h, flip_v, enable, anim_en  in  1 each  mirror X, mirror Y, show sprite, auto-animate.
REQ-017 frame_sel  in  FW  frame to show when anim_en=0.
REQ-018 rom_addr  out  AW  registered address to external sync ROM (1-cycle read latency).
REQ-019 rom_q  in  IDX_BITS  ROM data for rom_addr of previous cycle.
REQ-020 pix_idx  out  IDX_BITS; pix_opaque  out  1; blank_o  out  1: pixel result aligned to delayed blank.

Function
REQ-021 Shadow registers (pos_x, pos_y, flip_h, flip_v, enable) SHALL load only on cycles with frame_start=1; drawing uses shadow values only (no mid-frame tearing).
REQ-022 Stage 0: dx = DrawX - sx, dy = DrawY - sy in 11-bit unsigned arithmetic; inside = DrawX>=sx & DrawY>=sy & dx < SPR_W<<SCALE_LOG2 & dy < SPR_H<<SCALE_LOG2.
REQ-023 Texel u = dx>>SCALE_LOG2, v = dy>>SCALE_LOG2; if flip_h u = SPR_W-1-u; if flip_v v = SPR_H-1-v.
REQ-024 rom_addr SHALL register frame*SPR_W*SPR_H + v*SPR_W + u when inside, else 0.
REQ-025 Sprites extending past x=639 or y=479 SHALL clip; no wrap to opposite edge.
REQ-026 inside and blank SHALL be delayed to match ROM latency; outputs register one cycle after rom_q valid: DrawX/DrawY at cycle t -> pix_idx/pix_opaque/blank_o at t+2.
REQ-027 pix_opaque = inside_d & enable_shadow & blank_d & (rom_q != TRANSP_IDX); pix_idx = rom_q regardless.
REQ-028 Animation: on frame_start with anim_en=1, div counter increments; on reaching ANIM_DIV-1 it clears and frame advances, wrapping N_FRAMES-1 -> 0.
REQ-029 On frame_start with anim_en=0, frame loads frame_sel if frame_sel < N_FRAMES, else holds; div counter clears.
REQ-030 frame changes only on frame_start.

Reset
REQ-031 Reset=1 SHALL clear shadow registers, frame, div counter, pipeline registers, rom_addr, pix_idx, pix_opaque, blank_o to 0 on the next edge.
REQ-032 Reset has priority over simultaneous frame_start.
REQ-033 Reset mid-line: outputs 0 from next edge; pix_opaque stays 0 until an enable=1 value is latched by frame_start.

Verification
REQ-034 Defaults; pos=(100,50), enable=1, frame_sel=0, pulse frame_start; DrawX=100,DrawY=50 -> rom_addr=0 at t+1; DrawX=131,DrawY=81 -> rom_addr=1023; DrawX=132 -> inside=0, pix_opaque=0 at t+2.
REQ-035 flip_h=1,flip_v=1, frame_sel=2, same pos; DrawX=100,DrawY=50 -> rom_addr=2*1024+1023=3071.
REQ-036 SCALE_LOG2=1, pos=(0,0); DrawX=63,DrawY=63 -> u=v=31 addr=1023; DrawX=64 -> outside; rom_q=TRANSP_IDX inside -> pix_opaque=0.
REQ-037 pos=(620,0), DrawX=639 opaque; DrawX=0..11 -> pix_opaque=0 (clip, no wrap).
REQ-038 anim_en=1, ANIM_DIV=2: frame_start pulses 1..8 -> frame 0,1,1,2,2,3,3,0 after pulses 1..8 respectively; pos change mid-frame not visible until next frame_start.
REQ-039 Assert Reset on same cycle as frame_start with enable=1 -> all outputs 0, frame=0, pix_opaque=0 for rest of frame.
